// File: rtl/sim_halt_monitor.sv
// End-of-run detector for the cortex_m0 fetch stream: halts on BKPT, B ., a stuck PC
// or an exhausted cycle budget, and reports cause, PC and run statistics.
module sim_halt_monitor #(
    parameter logic [31:0] MAX_CYCLES  = 32'd1000,
    parameter int          LOOP_REPEAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr_pc,
    input  logic [15:0] instr,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] halt_pc,
    output logic [31:0] cycle_count,
    output logic [31:0] retired_count
);

    // state  | meaning
    // RUN    | watching fetches, counters advancing
    // HALTED | cause/pc latched, everything frozen until rst
    typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

    localparam logic [31:0] LOOP_REPEAT_W = 32'(LOOP_REPEAT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cause;
    logic [31:0] r_halt_pc;
    logic [31:0] r_cycles;
    logic [31:0] r_retired;
    logic [31:0] r_last_pc;
    logic [7:0]  r_rep;

    logic        w_run;
    logic [7:0]  w_rep_nxt;
    logic        w_ev_bkpt;
    logic        w_ev_self;
    logic        w_ev_rep;
    logic        w_ev_tmo;
    logic        w_halt_ev;
    logic [1:0]  w_cause;
    logic [31:0] w_pc;

    assign w_run     = (r_state == ST_RUN);
    // rep saturates so a very long stall cannot wrap back through LOOP_REPEAT
    assign w_rep_nxt = (instr_pc == r_last_pc) ? ((r_rep == 8'hFF) ? 8'hFF : r_rep + 8'd1)
                                               : 8'd1;
    assign w_ev_bkpt = w_run && instr_valid && (instr[15:8] == 8'hBE);
    assign w_ev_self = w_run && instr_valid && (instr == 16'hE7FE);
    assign w_ev_rep  = w_run && instr_valid && ({24'd0, w_rep_nxt} == LOOP_REPEAT_W);
    assign w_ev_tmo  = w_run && ((r_cycles + 32'd1) == MAX_CYCLES);
    assign w_halt_ev = w_ev_bkpt || w_ev_self || w_ev_rep || w_ev_tmo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (w_halt_ev) w_state_nxt = ST_HALTED;
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_cause = 2'd3;
        w_pc    = 32'd0;
        if (w_ev_bkpt) begin
            w_cause = 2'd0;
            w_pc    = instr_pc;
        end else if (w_ev_self) begin
            w_cause = 2'd1;
            w_pc    = instr_pc;
        end else if (w_ev_rep) begin
            w_cause = 2'd2;
            w_pc    = instr_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cause   <= 2'd0;
            r_halt_pc <= 32'd0;
            r_cycles  <= 32'd0;
            r_retired <= 32'd0;
            r_last_pc <= 32'd0;
            r_rep     <= 8'd0;
        end else if (w_run) begin
            r_cycles <= r_cycles + 32'd1;
            if (instr_valid) begin
                r_last_pc <= instr_pc;
                r_rep     <= w_rep_nxt;
                if (!w_halt_ev) r_retired <= r_retired + 32'd1;
            end
            if (w_halt_ev) begin
                r_cause   <= w_cause;
                r_halt_pc <= w_pc;
            end
        end
    end

    assign halted        = (r_state == ST_HALTED);
    assign halt_cause    = r_cause;
    assign halt_pc       = r_halt_pc;
    assign cycle_count   = r_cycles;
    assign retired_count = r_retired;

endmodule

// File: tb/tb_sim_halt_monitor.sv
// Bench for sim_halt_monitor: three instances with different cycle budgets share one
// fetch stream and are compared against a history-based model of the halt rules.
module tb_sim_halt_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        v;
    logic [31:0] pc;
    logic [15:0] ins;

    logic        o_h   [3];
    logic [1:0]  o_c   [3];
    logic [31:0] o_pc  [3];
    logic [31:0] o_cyc [3];
    logic [31:0] o_ret [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sim_halt_monitor u_a (
        .clk(clk), .rst(rst), .instr_valid(v), .instr_pc(pc), .instr(ins),
        .halted(o_h[0]), .halt_cause(o_c[0]), .halt_pc(o_pc[0]),
        .cycle_count(o_cyc[0]), .retired_count(o_ret[0]));

    sim_halt_monitor #(.MAX_CYCLES(32'd30)) u_b (
        .clk(clk), .rst(rst), .instr_valid(v), .instr_pc(pc), .instr(ins),
        .halted(o_h[1]), .halt_cause(o_c[1]), .halt_pc(o_pc[1]),
        .cycle_count(o_cyc[1]), .retired_count(o_ret[1]));

    sim_halt_monitor #(.MAX_CYCLES(32'd5)) u_c (
        .clk(clk), .rst(rst), .instr_valid(v), .instr_pc(pc), .instr(ins),
        .halted(o_h[2]), .halt_cause(o_c[2]), .halt_pc(o_pc[2]),
        .cycle_count(o_cyc[2]), .retired_count(o_ret[2]));

    // Reference model: halt decided from the list of valid fetch PCs seen since reset.
    bit          m_h   [3];
    logic [1:0]  m_c   [3];
    logic [31:0] m_pc  [3];
    logic [31:0] m_cyc [3];
    logic [31:0] m_ret [3];
    logic [31:0] hist[$];
    int unsigned maxc [3] = '{1000, 30, 5};

    function automatic int trailing_same();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == hist[hist.size() - 1]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int d = 0; d < 3; d++) begin
            m_h[d] = 0; m_c[d] = 0; m_pc[d] = 0; m_cyc[d] = 0; m_ret[d] = 0;
        end
    endtask

    task automatic step(input bit vv, input logic [31:0] p, input logic [15:0] ii);
        int  tr;
        bit  bk, sb, rp, to;
        v = vv; pc = p; ins = ii;
        @(posedge clk);
        if (vv) hist.push_back(p);
        tr = trailing_same();
        for (int d = 0; d < 3; d++) begin
            if (!m_h[d]) begin
                bk = vv && (ii[15:8] == 8'hBE);
                sb = vv && (ii == 16'hE7FE);
                rp = vv && (tr == 4);
                to = (m_cyc[d] + 1 == maxc[d]);
                if (bk || sb || rp || to) begin
                    m_h[d]  = 1;
                    m_c[d]  = bk ? 2'd0 : sb ? 2'd1 : rp ? 2'd2 : 2'd3;
                    m_pc[d] = (bk || sb || rp) ? p : 32'd0;
                end else if (vv) begin
                    m_ret[d]++;
                end
                m_cyc[d]++;
            end
        end
        #1;
    endtask

    task automatic do_reset(input bit with_event);
        rst = 1'b1; v = with_event; pc = 32'h8; ins = 16'hBE00;
        @(posedge clk);
        #1;
        rst = 1'b0; v = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_h[d] !== 1'b0 || o_c[d] !== 2'd0 || o_pc[d] !== 32'd0 ||
                o_cyc[d] !== 32'd0 || o_ret[d] !== 32'd0) begin
                errors++;
                $display("FAIL reset[%0d] got h=%0b c=%0d pc=%h cyc=%0d ret=%0d, required all 0",
                         d, o_h[d], o_c[d], o_pc[d], o_cyc[d], o_ret[d]);
            end
        end
    endtask

    task automatic test_bkpt();
        do_reset(1'b0);
        step(1, 32'h0, 16'h2000);
        step(1, 32'h2, 16'h2000);
        step(1, 32'h4, 16'h2000);
        checks++;
        if (o_h[0] !== 1'b0) begin
            errors++; $display("FAIL bkpt_pre got halted=%0b required 0", o_h[0]);
        end
        step(1, 32'h6, 16'hBE01);
        checks++;
        if (o_h[0] !== 1'b1 || o_c[0] !== 2'd0 || o_pc[0] !== 32'h6 ||
            o_ret[0] !== 32'd3 || o_cyc[0] !== 32'd4) begin
            errors++;
            $display("FAIL bkpt got h=%0b c=%0d pc=%h ret=%0d cyc=%0d, required 1 0 6 3 4",
                     o_h[0], o_c[0], o_pc[0], o_ret[0], o_cyc[0]);
        end
    endtask

    task automatic test_self_branch();
        do_reset(1'b0);
        step(1, 32'h10, 16'hE7FE);
        checks++;
        if (o_h[0] !== 1'b1 || o_c[0] !== 2'd1 || o_pc[0] !== 32'h10 ||
            o_ret[0] !== 32'd0 || o_cyc[0] !== 32'd1) begin
            errors++;
            $display("FAIL self_branch got h=%0b c=%0d pc=%h ret=%0d cyc=%0d, required 1 1 10 0 1",
                     o_h[0], o_c[0], o_pc[0], o_ret[0], o_cyc[0]);
        end
        step(1, 32'h40, 16'hBE00);
        step(1, 32'h44, 16'h2000);
        step(0, 32'h48, 16'h2000);
        checks++;
        if (o_h[0] !== 1'b1 || o_c[0] !== 2'd1 || o_pc[0] !== 32'h10 ||
            o_ret[0] !== 32'd0 || o_cyc[0] !== 32'd1) begin
            errors++;
            $display("FAIL halted_frozen got h=%0b c=%0d pc=%h ret=%0d cyc=%0d, required 1 1 10 0 1",
                     o_h[0], o_c[0], o_pc[0], o_ret[0], o_cyc[0]);
        end
    endtask

    task automatic test_pc_repeat();
        do_reset(1'b0);
        step(1, 32'h20, 16'h46C0);
        step(0, 32'h20, 16'h46C0);
        step(1, 32'h20, 16'h46C0);
        step(0, 32'h24, 16'h46C0);
        step(1, 32'h20, 16'h46C0);
        checks++;
        if (o_h[0] !== 1'b0) begin
            errors++; $display("FAIL repeat_pre got halted=%0b required 0", o_h[0]);
        end
        step(1, 32'h20, 16'h46C0);
        checks++;
        if (o_h[0] !== 1'b1 || o_c[0] !== 2'd2 || o_pc[0] !== 32'h20 ||
            o_ret[0] !== 32'd3 || o_cyc[0] !== 32'd6) begin
            errors++;
            $display("FAIL repeat got h=%0b c=%0d pc=%h ret=%0d cyc=%0d, required 1 2 20 3 6",
                     o_h[0], o_c[0], o_pc[0], o_ret[0], o_cyc[0]);
        end
    endtask

    task automatic test_timeout();
        do_reset(1'b0);
        for (int i = 0; i < 29; i++) step(0, 32'h0, 16'h0);
        checks++;
        if (o_h[1] !== 1'b0 || o_cyc[1] !== 32'd29) begin
            errors++;
            $display("FAIL timeout_pre got h=%0b cyc=%0d, required 0 29", o_h[1], o_cyc[1]);
        end
        step(0, 32'h0, 16'h0);
        checks++;
        if (o_h[1] !== 1'b1 || o_c[1] !== 2'd3 || o_pc[1] !== 32'd0 || o_cyc[1] !== 32'd30) begin
            errors++;
            $display("FAIL timeout got h=%0b c=%0d pc=%h cyc=%0d, required 1 3 0 30",
                     o_h[1], o_c[1], o_pc[1], o_cyc[1]);
        end
        step(0, 32'h0, 16'h0);
        checks++;
        if (o_cyc[1] !== 32'd30) begin
            errors++; $display("FAIL timeout_freeze got cyc=%0d required 30", o_cyc[1]);
        end
    endtask

    task automatic test_priority();
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 16'h0);
        step(1, 32'h30, 16'hBE00);
        checks++;
        if (o_h[2] !== 1'b1 || o_c[2] !== 2'd0 || o_pc[2] !== 32'h30 || o_cyc[2] !== 32'd5) begin
            errors++;
            $display("FAIL bkpt_vs_timeout got h=%0b c=%0d pc=%h cyc=%0d, required 1 0 30 5",
                     o_h[2], o_c[2], o_pc[2], o_cyc[2]);
        end
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step(1, 32'h40, 16'h46C0);
        step(1, 32'h40, 16'hE7FE);
        checks++;
        if (o_h[0] !== 1'b1 || o_c[0] !== 2'd1 || o_pc[0] !== 32'h40 || o_ret[0] !== 32'd3) begin
            errors++;
            $display("FAIL self_vs_repeat got h=%0b c=%0d pc=%h ret=%0d, required 1 1 40 3",
                     o_h[0], o_c[0], o_pc[0], o_ret[0]);
        end
    endtask

    task automatic test_rst_midrun();
        do_reset(1'b0);
        step(1, 32'h20, 16'h46C0);
        step(1, 32'h20, 16'h46C0);
        do_reset(1'b0);
        checks++;
        if (o_h[0] !== 1'b0 || o_c[0] !== 2'd0 || o_pc[0] !== 32'd0 ||
            o_cyc[0] !== 32'd0 || o_ret[0] !== 32'd0) begin
            errors++;
            $display("FAIL rst_midrun got h=%0b c=%0d pc=%h cyc=%0d ret=%0d, required all 0",
                     o_h[0], o_c[0], o_pc[0], o_cyc[0], o_ret[0]);
        end
        step(1, 32'h20, 16'h46C0);
        step(1, 32'h20, 16'h46C0);
        step(1, 32'h20, 16'h46C0);
        checks++;
        if (o_h[0] !== 1'b0 || o_ret[0] !== 32'd3) begin
            errors++;
            $display("FAIL rst_fresh_count got h=%0b ret=%0d, required 0 3", o_h[0], o_ret[0]);
        end
        step(1, 32'h20, 16'h46C0);
        checks++;
        if (o_h[0] !== 1'b1 || o_c[0] !== 2'd2 || o_ret[0] !== 32'd3 || o_cyc[0] !== 32'd4) begin
            errors++;
            $display("FAIL rst_repeat got h=%0b c=%0d ret=%0d cyc=%0d, required 1 2 3 4",
                     o_h[0], o_c[0], o_ret[0], o_cyc[0]);
        end
        // last_pc starts at 0, so three fetches at PC 0 are only rep=3
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step(1, 32'h0, 16'h2000);
        checks++;
        if (o_h[0] !== 1'b0) begin
            errors++; $display("FAIL pc_zero_first got halted=%0b required 0", o_h[0]);
        end
    endtask

    task automatic test_random();
        bit          rv;
        logic [31:0] rp;
        logic [15:0] ri;
        int          sel;
        for (int run = 0; run < 8; run++) begin
            do_reset(1'b0);
            for (int s = 0; s < 40; s++) begin
                rv  = ($urandom_range(0, 3) != 0);
                rp  = 32'(2 * $urandom_range(0, 2));
                sel = $urandom_range(0, 19);
                if (sel == 0)      ri = {8'hBE, 8'($urandom)};
                else if (sel == 1) ri = 16'hE7FE;
                else               ri = 16'($urandom);
                step(rv, rp, ri);
                for (int d = 0; d < 3; d++) begin
                    checks++;
                    if (o_h[d] !== m_h[d] || o_c[d] !== m_c[d] || o_pc[d] !== m_pc[d] ||
                        o_cyc[d] !== m_cyc[d] || o_ret[d] !== m_ret[d]) begin
                        errors++;
                        $display("FAIL random[%0d] run=%0d step=%0d got h=%0b c=%0d pc=%h cyc=%0d ret=%0d, required h=%0b c=%0d pc=%h cyc=%0d ret=%0d",
                                 d, run, s, o_h[d], o_c[d], o_pc[d], o_cyc[d], o_ret[d],
                                 m_h[d], m_c[d], m_pc[d], m_cyc[d], m_ret[d]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; v = 1'b0; pc = 32'h0; ins = 16'h0;
        model_clear();
        test_reset();
        test_bkpt();
        test_self_branch();
        test_pc_repeat();
        test_timeout();
        test_priority();
        test_rst_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sim_halt_monitor.md
# sim_halt_monitor

Cycle-accurate end-of-run detector instantiated beside the `cortex_m0` core. It watches the instruction-fetch stream and declares the run finished on a Thumb BKPT, a self-branch (`B .`), a PC stuck for a set number of fetches, or a cycle budget running out. It reports halt status, cause, PC, and cycle and instruction counts back to the testbench, which stops on `halted` rather than on a fixed cycle count.

## Interface
- `MAX_CYCLES`, default 32'd1000: cycle budget; the run halts with cause 3 when it is exhausted (must be ≥ 1).
- `LOOP_REPEAT`, default 4: number of consecutive valid fetches from an identical PC that triggers cause 2 (must be ≥ 2).
- `clk`  input  1: the single clock; all state updates on the rising edge.
- `rst`  input  1: reset, synchronous, active-high.
- `instr_valid`  input  1: a fetched instruction is presented this cycle.
- `instr_pc`  input  32: address of the presented instruction.
- `instr`  input  16: Thumb halfword of the presented instruction.
- `halted`  output  1: run finished; sticky until `rst`.
- `halt_cause`  output  2: 0 = BKPT, 1 = self-branch, 2 = PC repeat, 3 = timeout.
- `halt_pc`  output  32: PC of the halting instruction; 0 for a timeout.
- `cycle_count`  output  32: cycles spent in RUN, including the halting cycle.
- `retired_count`  output  32: valid fetches accepted in RUN, excluding the halting fetch.

## Operation
- FSM with two states:
  - RUN is the reset state.
  - RUN → HALTED on any halt event.
  - HALTED → HALTED until `rst`. It has no other exit.
- Events are evaluated only in RUN, and only when `instr_valid` = 1, except timeout:
  - BKPT: `instr[15:8]` == 8'hBE.
  - Self-branch: `instr` == 16'hE7FE.
  - PC repeat: uses an internal `last_pc` register and a repeat counter `rep`, 8 bits, saturating.
    - On a valid fetch where `instr_pc` == `last_pc`, `rep` <= `rep` + 1.
    - Otherwise `last_pc` <= `instr_pc` and `rep` <= 1.
    - The event fires when the post-update `rep` equals `LOOP_REPEAT`.
  - Timeout: fires when `cycle_count` + 1 == `MAX_CYCLES` at a RUN edge. It is independent of `instr_valid`.
- Simultaneous events resolve by fixed priority: BKPT > self-branch > PC repeat > timeout. Only the winning cause is latched.
- A `B .` fetch therefore halts with cause 1 on its first fetch, never cause 2.
- Counters:
  - In RUN, `cycle_count` increments on every edge, including the halting edge.
  - In RUN, `retired_count` increments on each valid fetch that does not raise an event.
  - In HALTED, both counters freeze.
  - Counters wrap modulo 2^32 and carry no overflow flag. `MAX_CYCLES` bounds them in practice.
- Inputs arriving while HALTED are ignored entirely: no counting, no state change.
- `rst` asserted in any state, including mid-run with `rep` > 0, returns to RUN with every register cleared on that edge.

## Timing
- Reset values: `halted` = 0, `halt_cause` = 0, `halt_pc` = 0, `cycle_count` = 0, `retired_count` = 0, `last_pc` = 0, `rep` = 0.
- All outputs are registered. There is no combinational path from input to output.
- Halt latency is 1 cycle. An event sampled at edge N makes `halted`, `halt_cause` and `halt_pc` valid after edge N, all updated on the same edge.
- Timeout: after `MAX_CYCLES` RUN edges, `halted` = 1 and `cycle_count` == `MAX_CYCLES`.
- `rst` has priority over every event on the same edge. An event coincident with `rst` is discarded.
- First cycle after `rst` deasserts: `last_pc` = 0 and `rep` = 0, so a first fetch at PC 0 sets `rep` to 1, not 2.

## Test plan
- Reset, then present valid fetches at PC 0x00, 0x02, 0x04 with `instr` 0x2000, then `instr` 0xBE01 at PC 0x06 → `halted` = 1 one cycle later, `halt_cause` = 0, `halt_pc` = 0x06, `retired_count` = 3, `cycle_count` = 4.
- Valid fetch of 0xE7FE at PC 0x10 on cycle 1 → `halt_cause` = 1, `halt_pc` = 0x10, `retired_count` = 0. Further fetches produce no change in any output.
- Four consecutive valid fetches of 0x46C0 at PC 0x20 with `LOOP_REPEAT` = 4 → halts on the 4th with `halt_cause` = 2, `halt_pc` = 0x20, `retired_count` = 3. A bubble (`instr_valid` = 0) between fetches does not reset `rep`.
- `MAX_CYCLES` = 30 with `instr_valid` held 0 → `halted` rises after edge 30, `halt_cause` = 3, `halt_pc` = 0, `cycle_count` = 30.
- `MAX_CYCLES` = 5 with 0xBE00 presented on edge 5 → cause 0, not 3. In a separate check, 0xE7FE at a PC that is already repeating → cause 1.
- Pulse `rst` for one cycle mid-run after 2 repeats at the same PC → all outputs read 0. Two more fetches at that PC do not halt. The halt requires `LOOP_REPEAT` fresh fetches.
